// File: rtl/ddr_rx_pkg.sv
// Shared mode encodings, bit-count constants and parity helper for the HDR-DDR receive path.
package ddr_rx_pkg;

   typedef enum logic [3:0] {
      MODE_PREAMBLE = 4'b0000,
      MODE_BYTE     = 4'b0011,
      MODE_TOKEN    = 4'b0101,
      MODE_PARITY   = 4'b0110,
      MODE_CRC      = 4'b0111,
      MODE_ERROR    = 4'b1111
   } rx_mode_e;

   localparam logic [3:0] CRC_TOKEN = 4'hC;

   localparam logic [3:0] PRE_BITS    = 4'd1;
   localparam logic [3:0] BYTE_BITS   = 4'd8;
   localparam logic [3:0] PARITY_BITS = 4'd2;
   localparam logic [3:0] TOKEN_BITS  = 4'd4;
   localparam logic [3:0] CRC_BITS    = 4'd5;

   // Zero means the mode has no fixed length (error recovery, unused codes).
   function automatic logic [3:0] mode_bits(input logic [3:0] mode);
      logic [3:0] n;
      n = 4'd0;
      case (mode)
         MODE_PREAMBLE: n = PRE_BITS;
         MODE_BYTE:     n = BYTE_BITS;
         MODE_PARITY:   n = PARITY_BITS;
         MODE_TOKEN:    n = TOKEN_BITS;
         MODE_CRC:      n = CRC_BITS;
         default:       n = 4'd0;
      endcase
      return n;
   endfunction

   // Returns {PA1, PA0}: PA1 covers odd bits, PA0 covers even bits and is inverted.
   function automatic logic [1:0] parity_expected(input logic [15:0] w);
      logic pa1;
      logic pa0;
      pa1 = 1'b0;
      pa0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pa1 = pa1 ^ w[2*i+1];
         pa0 = pa0 ^ w[2*i];
      end
      return {pa1, pa0};
   endfunction

endpackage

// File: rtl/ddr_rx_if.sv
// Signal bundle between the DDR/CCC FSM side (master) and the ddr_rx receiver (slave).
interface ddr_rx_if;
   logic       i_sclgen_scl;
   logic       i_sclgen_scl_pos_edge;
   logic       i_sclgen_scl_neg_edge;
   logic       i_ddrccc_rx_en;
   logic       i_sdahnd_rx_sda;
   logic [3:0] i_ddrccc_rx_mode;
   logic [4:0] i_crc_value;
   logic       i_crc_valid;
   logic [7:0] o_regfcrc_rx_data_out;
   logic       o_ddrccc_rx_mode_done;
   logic       o_ddrccc_pre;
   logic       o_ddrccc_error;
   logic       o_crc_en;
   logic       o_crc_data_valid;
   logic       o_ddrccc_error_done;

   modport master (
      output i_sclgen_scl, i_sclgen_scl_pos_edge, i_sclgen_scl_neg_edge, i_ddrccc_rx_en,
             i_sdahnd_rx_sda, i_ddrccc_rx_mode, i_crc_value, i_crc_valid,
      input  o_regfcrc_rx_data_out, o_ddrccc_rx_mode_done, o_ddrccc_pre, o_ddrccc_error,
             o_crc_en, o_crc_data_valid, o_ddrccc_error_done
   );

   modport slave (
      input  i_sclgen_scl, i_sclgen_scl_pos_edge, i_sclgen_scl_neg_edge, i_ddrccc_rx_en,
             i_sdahnd_rx_sda, i_ddrccc_rx_mode, i_crc_value, i_crc_valid,
      output o_regfcrc_rx_data_out, o_ddrccc_rx_mode_done, o_ddrccc_pre, o_ddrccc_error,
             o_crc_en, o_crc_data_valid, o_ddrccc_error_done
   );
endinterface

// File: rtl/ddr_rx_bit_counter.sv
// Sample qualification and per-mode bit counter; flags the sample that completes a mode.
module rx_bit_counter
   import ddr_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_en,
   input  logic       pos_edge,
   input  logic       neg_edge,
   input  logic [3:0] rx_mode,
   output logic       sample,
   output logic       restart,
   output logic       last_bit
);
   logic [3:0] cnt_q;
   logic [3:0] prev_mode_q;
   logic [3:0] cnt_base;
   logic [3:0] term;

   assign sample   = rx_en & (pos_edge | neg_edge);
   assign restart  = !rx_en || (rx_mode != prev_mode_q);
   assign term     = mode_bits(rx_mode);
   // A sample landing in the mode-change cycle is bit zero of the new mode.
   assign cnt_base = restart ? 4'd0 : cnt_q;
   assign last_bit = sample && (term != 4'd0) && ((cnt_base + 4'd1) == term);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= 4'd0;
         prev_mode_q <= 4'd0;
      end else begin
         prev_mode_q <= rx_mode;
         if (last_bit)
            cnt_q <= 4'd0;
         else if (sample && (term != 4'd0))
            cnt_q <= cnt_base + 4'd1;
         else
            cnt_q <= cnt_base;
      end
   end
endmodule

// File: rtl/ddr_rx.sv
// HDR-DDR receive datapath: preamble, byte, parity, token, CRC and error-recovery capture.
// Define RX_CRC_CHECK_EN to compare the received CRC5 against i_crc_value.
module ddr_rx
   import ddr_rx_pkg::*;
#(
   parameter int ERR_MIN_ONES = 38
) (
   input logic     i_sys_clk,
   input logic     i_sys_rst,
   ddr_rx_if.slave rx
);
   localparam int             OW       = $clog2(ERR_MIN_ONES + 1);
   localparam logic [OW-1:0]  ONES_MAX = OW'(ERR_MIN_ONES);

   logic          sample;
   logic          restart;
   logic          last_bit;
   logic          sda;
   logic [3:0]    mode;
   logic [7:0]    shift_q;
   logic [7:0]    shift_d;
   logic [15:0]   word_q;
   logic [OW-1:0] ones_q;
   logic [OW-1:0] ones_base;
   logic [7:0]    data_q;
   logic          pre_q, err_q, done_q, crc_en_q, crc_dv_q, err_done_q;
   logic          unused_ok;

   assign sda       = rx.i_sdahnd_rx_sda;
   assign mode      = rx.i_ddrccc_rx_mode;
   assign shift_d   = {shift_q[6:0], sda};
   assign ones_base = restart ? '0 : ones_q;
   assign unused_ok = rx.i_sclgen_scl ^ (^rx.i_crc_value) ^ rx.i_crc_valid;

   rx_bit_counter u_cnt (
      .clk      (i_sys_clk),
      .rst      (i_sys_rst),
      .rx_en    (rx.i_ddrccc_rx_en),
      .pos_edge (rx.i_sclgen_scl_pos_edge),
      .neg_edge (rx.i_sclgen_scl_neg_edge),
      .rx_mode  (mode),
      .sample   (sample),
      .restart  (restart),
      .last_bit (last_bit)
   );

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         shift_q    <= 8'd0;
         word_q     <= 16'd0;
         ones_q     <= '0;
         data_q     <= 8'd0;
         pre_q      <= 1'b1;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         crc_en_q   <= 1'b0;
         crc_dv_q   <= 1'b0;
         err_done_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         crc_dv_q   <= 1'b0;
         err_done_q <= 1'b0;
         crc_en_q   <= rx.i_ddrccc_rx_en && (mode == MODE_BYTE);
         if (sample)
            shift_q <= shift_d;

         // Error recovery: a run of highs long enough, closed by a low.
         if (sample && (mode == MODE_ERROR)) begin
            if (sda) begin
               ones_q <= (ones_base == ONES_MAX) ? ones_base : ones_base + 1'b1;
            end else begin
               ones_q <= '0;
               if (ones_base >= ONES_MAX) begin
                  done_q     <= 1'b1;
                  err_done_q <= 1'b1;
                  err_q      <= 1'b0;
               end
            end
         end else begin
            ones_q <= ones_base;
         end

         if (last_bit) begin
            done_q <= 1'b1;
            case (mode)
               MODE_PREAMBLE: pre_q <= sda;
               MODE_BYTE: begin
                  data_q   <= shift_d;
                  word_q   <= {word_q[7:0], shift_d};
                  crc_dv_q <= 1'b1;
               end
               MODE_PARITY: if (shift_d[1:0] != parity_expected(word_q)) err_q <= 1'b1;
               MODE_TOKEN:  if (shift_d[3:0] != CRC_TOKEN) err_q <= 1'b1;
               MODE_CRC: begin
`ifdef RX_CRC_CHECK_EN
                  if (rx.i_crc_valid && (shift_d[4:0] != rx.i_crc_value)) err_q <= 1'b1;
`else
                  err_q <= err_q;
`endif
               end
               default: ;
            endcase
         end
      end
   end

   assign rx.o_regfcrc_rx_data_out = data_q;
   assign rx.o_ddrccc_rx_mode_done = done_q;
   assign rx.o_ddrccc_pre          = pre_q;
   assign rx.o_ddrccc_error        = err_q;
   assign rx.o_crc_en              = crc_en_q;
   assign rx.o_crc_data_valid      = crc_dv_q;
   assign rx.o_ddrccc_error_done   = err_done_q;
endmodule

// File: tb/tb_ddr_rx.sv
// Self-checking bench for ddr_rx: directed vector table, corner sequences, random stimulus vs model.
module tb_ddr_rx;
   import ddr_rx_pkg::*;

   localparam int ERR_N = 38;
`ifdef RX_CRC_CHECK_EN
   localparam logic CRC_CHK = 1'b1;
`else
   localparam logic CRC_CHK = 1'b0;
`endif

   logic i_sys_clk_tb;
   logic i_sys_rst_tb;
   ddr_rx_if bus ();

   ddr_rx #(.ERR_MIN_ONES(ERR_N)) dut (
      .i_sys_clk (i_sys_clk_tb),
      .i_sys_rst (i_sys_rst_tb),
      .rx        (bus)
   );

   // clock / reset
   initial i_sys_clk_tb = 1'b0;
   always #5 i_sys_clk_tb = ~i_sys_clk_tb;

   int checks = 0;
   int errors = 0;
   int done_seen, crcv_seen, errd_seen;
   logic edge_ph = 1'b0;

   // reference model state
   logic [15:0] m_w;
   logic        m_pre;
   logic        m_err;
   logic [7:0]  exp_q[$];

   typedef struct {
      logic [3:0]  mode;
      int          n;
      logic [63:0] bits;
      logic [4:0]  cv;
      logic        cvld;
      logic [7:0]  e_data;
      logic        e_pre;
      logic        e_err;
      int          e_done;
      int          e_crcv;
      int          e_errd;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every CRC byte strobe must carry the next expected byte
   always @(negedge i_sys_clk_tb) begin
      if (bus.o_ddrccc_rx_mode_done === 1'b1) done_seen++;
      if (bus.o_ddrccc_error_done === 1'b1) errd_seen++;
      if (bus.o_crc_data_valid === 1'b1) begin
         crcv_seen++;
         if (exp_q.size() == 0) chk("crc_byte_unexpected", 1, 0);
         else chk("crc_byte", bus.o_regfcrc_rx_data_out, exp_q.pop_front());
      end
   end

   task automatic send_bit(input logic b, input logic both);
      @(negedge i_sys_clk_tb);
      bus.i_sdahnd_rx_sda = b;
      if (both) begin
         bus.i_sclgen_scl_pos_edge = 1'b1;
         bus.i_sclgen_scl_neg_edge = 1'b1;
      end else if (edge_ph) bus.i_sclgen_scl_neg_edge = 1'b1;
      else bus.i_sclgen_scl_pos_edge = 1'b1;
      bus.i_sclgen_scl = ~edge_ph;
      edge_ph = ~edge_ph;
      @(negedge i_sys_clk_tb);
      bus.i_sclgen_scl_pos_edge = 1'b0;
      bus.i_sclgen_scl_neg_edge = 1'b0;
   endtask

   task automatic run_txn(input logic [3:0] mode, input int n, input logic [63:0] bits,
                          input logic [4:0] cv, input logic cvld, input logic both);
      @(negedge i_sys_clk_tb);
      bus.i_ddrccc_rx_mode = mode;
      bus.i_crc_value = cv;
      bus.i_crc_valid = cvld;
      done_seen = 0; crcv_seen = 0; errd_seen = 0;
      for (int i = n - 1; i >= 0; i--) send_bit(bits[i], both);
      @(negedge i_sys_clk_tb);
      @(negedge i_sys_clk_tb);
   endtask

   function automatic logic [1:0] model_parity();
      int odd_ones = 0;
      int even_ones = 0;
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 1) odd_ones += int'(m_w[i]);
         else even_ones += int'(m_w[i]);
      end
      return {1'(odd_ones % 2), 1'((even_ones + 1) % 2)};
   endfunction

   // Behavioural model: what a transaction of n bits (sent MSB first) should produce.
   task automatic model_txn(input logic [3:0] mode, input int n, input logic [63:0] bits,
                            input logic [4:0] cv, input logic cvld,
                            output int e_done, output int e_crcv, output int e_errd);
      int run;
      e_done = 0; e_crcv = 0; e_errd = 0;
      case (mode)
         4'b0000: begin m_pre = bits[0]; e_done = 1; end
         4'b0011: begin
            m_w = {m_w[7:0], bits[7:0]};
            exp_q.push_back(bits[7:0]);
            e_done = 1; e_crcv = 1;
         end
         4'b0110: begin if (bits[1:0] != model_parity()) m_err = 1'b1; e_done = 1; end
         4'b0101: begin if (bits[3:0] != 4'hC) m_err = 1'b1; e_done = 1; end
         4'b0111: begin if (CRC_CHK && cvld && (bits[4:0] != cv)) m_err = 1'b1; e_done = 1; end
         4'b1111: begin
            run = 0;
            for (int i = n - 1; i >= 0; i--) begin
               if (bits[i]) run++;
               else begin
                  if (run >= ERR_N) begin e_done++; e_errd++; m_err = 1'b0; end
                  run = 0;
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic check_vals(input string tag, input logic [3:0] mode, input logic [7:0] e_data,
                             input logic e_pre, input logic e_err, input int e_done,
                             input int e_crcv, input int e_errd);
      chk({tag, "/data"}, bus.o_regfcrc_rx_data_out, e_data);
      chk({tag, "/pre"}, bus.o_ddrccc_pre, e_pre);
      chk({tag, "/err"}, bus.o_ddrccc_error, e_err);
      chk({tag, "/done_cnt"}, done_seen, e_done);
      chk({tag, "/crc_dv_cnt"}, crcv_seen, e_crcv);
      chk({tag, "/err_done_cnt"}, errd_seen, e_errd);
      chk({tag, "/crc_en"}, bus.o_crc_en, mode == 4'b0011);
   endtask

   initial begin
      int d, c, e, n, sel, nones;
      logic [63:0] b;
      logic [3:0] mode;
      logic [4:0] cv;
      logic cvld, both;

      tbl[0]  = '{4'b0000, 1, 64'h0, 5'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0, 0};
      tbl[1]  = '{4'b0011, 8, 64'h00, 5'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1, 0};
      tbl[2]  = '{4'b0011, 8, 64'h00, 5'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1, 0};
      tbl[3]  = '{4'b0110, 2, 64'h1, 5'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0, 0};
      tbl[4]  = '{4'b0011, 8, 64'h85, 5'h0, 1'b0, 8'h85, 1'b0, 1'b0, 1, 1, 0};
      tbl[5]  = '{4'b0011, 8, 64'h2B, 5'h0, 1'b0, 8'h2B, 1'b0, 1'b0, 1, 1, 0};
      tbl[6]  = '{4'b0110, 2, 64'h1, 5'h0, 1'b0, 8'h2B, 1'b0, 1'b1, 1, 0, 0};
      tbl[7]  = '{4'b1111, 39, 64'h7F_FFFF_FFFE, 5'h0, 1'b0, 8'h2B, 1'b0, 1'b0, 1, 0, 1};
      tbl[8]  = '{4'b0101, 4, 64'hC, 5'h0, 1'b0, 8'h2B, 1'b0, 1'b0, 1, 0, 0};
      tbl[9]  = '{4'b0101, 4, 64'h3, 5'h0, 1'b0, 8'h2B, 1'b0, 1'b1, 1, 0, 0};
      tbl[10] = '{4'b1111, 11, 64'h7FE, 5'h0, 1'b0, 8'h2B, 1'b0, 1'b1, 0, 0, 0};
      tbl[11] = '{4'b1111, 39, 64'h7F_FFFF_FFFE, 5'h0, 1'b0, 8'h2B, 1'b0, 1'b0, 1, 0, 1};
      tbl[12] = '{4'b0111, 5, 64'h15, 5'h15, 1'b1, 8'h2B, 1'b0, 1'b0, 1, 0, 0};
      tbl[13] = '{4'b0111, 5, 64'h1F, 5'h15, 1'b1, 8'h2B, 1'b0, CRC_CHK, 1, 0, 0};
      tbl[14] = '{4'b0000, 1, 64'h1, 5'h0, 1'b0, 8'h2B, 1'b1, CRC_CHK, 1, 0, 0};

      bus.i_sclgen_scl = 1'b0;
      bus.i_sclgen_scl_pos_edge = 1'b0;
      bus.i_sclgen_scl_neg_edge = 1'b0;
      bus.i_ddrccc_rx_en = 1'b0;
      bus.i_sdahnd_rx_sda = 1'b1;
      bus.i_ddrccc_rx_mode = 4'b0000;
      bus.i_crc_value = 5'h0;
      bus.i_crc_valid = 1'b0;
      i_sys_rst_tb = 1'b1;
      m_w = 16'h0; m_pre = 1'b1; m_err = 1'b0;
      done_seen = 0; crcv_seen = 0; errd_seen = 0;
      repeat (3) @(negedge i_sys_clk_tb);
      i_sys_rst_tb = 1'b0;
      check_vals("reset", 4'b0000, 8'h00, 1'b1, 1'b0, 0, 0, 0);
      bus.i_ddrccc_rx_en = 1'b1;

      // directed vector table
      for (int i = 0; i < 15; i++) begin
         model_txn(tbl[i].mode, tbl[i].n, tbl[i].bits, tbl[i].cv, tbl[i].cvld, d, c, e);
         run_txn(tbl[i].mode, tbl[i].n, tbl[i].bits, tbl[i].cv, tbl[i].cvld, 1'b0);
         check_vals($sformatf("vec%0d", i), tbl[i].mode, tbl[i].e_data, tbl[i].e_pre,
                    tbl[i].e_err, tbl[i].e_done, tbl[i].e_crcv, tbl[i].e_errd);
      end

      // enable low mid-byte: partial bits are discarded, outputs hold
      @(negedge i_sys_clk_tb);
      bus.i_ddrccc_rx_mode = 4'b0011;
      done_seen = 0; crcv_seen = 0; errd_seen = 0;
      repeat (3) send_bit(1'b1, 1'b0);
      bus.i_ddrccc_rx_en = 1'b0;
      repeat (8) send_bit(1'b0, 1'b0);
      check_vals("en_low_hold", 4'b0000, m_w[7:0], m_pre, m_err, 0, 0, 0);
      bus.i_ddrccc_rx_en = 1'b1;
      model_txn(4'b0011, 8, 64'hA5, 5'h0, 1'b0, d, c, e);
      run_txn(4'b0011, 8, 64'hA5, 5'h0, 1'b0, 1'b0);
      check_vals("en_restart", 4'b0011, 8'hA5, m_pre, m_err, 1, 1, 0);

      // both edge pulses in one cycle count as a single sample
      model_txn(4'b0011, 8, 64'h3C, 5'h0, 1'b0, d, c, e);
      run_txn(4'b0011, 8, 64'h3C, 5'h0, 1'b0, 1'b1);
      check_vals("both_edges", 4'b0011, 8'h3C, m_pre, m_err, 1, 1, 0);

      // mode switch mid-byte: token starts counting from its own first sample
      @(negedge i_sys_clk_tb);
      bus.i_ddrccc_rx_mode = 4'b0011;
      repeat (3) send_bit(1'b0, 1'b0);
      model_txn(4'b0101, 4, 64'hC, 5'h0, 1'b0, d, c, e);
      run_txn(4'b0101, 4, 64'hC, 5'h0, 1'b0, 1'b0);
      check_vals("mode_switch", 4'b0101, m_w[7:0], m_pre, m_err, 1, 0, 0);

      // reset mid-byte aborts with no done pulse and clears the word register
      @(negedge i_sys_clk_tb);
      bus.i_ddrccc_rx_mode = 4'b0011;
      done_seen = 0; crcv_seen = 0; errd_seen = 0;
      repeat (4) send_bit(1'b1, 1'b0);
      i_sys_rst_tb = 1'b1;
      @(negedge i_sys_clk_tb);
      i_sys_rst_tb = 1'b0;
      m_w = 16'h0; m_pre = 1'b1; m_err = 1'b0;
      check_vals("mid_reset", 4'b0000, 8'h00, 1'b1, 1'b0, 0, 0, 0);
      model_txn(4'b0011, 8, 64'h5A, 5'h0, 1'b0, d, c, e);
      run_txn(4'b0011, 8, 64'h5A, 5'h0, 1'b0, 1'b0);
      check_vals("post_reset_byte", 4'b0011, 8'h5A, 1'b1, 1'b0, 1, 1, 0);

      // random transactions against the model
      for (int t = 0; t < 80; t++) begin
         sel = $urandom_range(0, 8);
         cv = 5'($urandom_range(0, 31));
         cvld = 1'($urandom_range(0, 1));
         both = ($urandom_range(0, 7) == 0);
         case (sel)
            0: begin mode = 4'b0000; n = 1; b = 64'($urandom_range(0, 1)); end
            1, 2: begin mode = 4'b0011; n = 8; b = 64'($urandom_range(0, 255)); end
            3: begin
               mode = 4'b0110; n = 2;
               b = $urandom_range(0, 1) ? 64'(model_parity()) : 64'($urandom_range(0, 3));
            end
            4: begin
               mode = 4'b0101; n = 4;
               b = $urandom_range(0, 1) ? 64'hC : 64'($urandom_range(0, 15));
            end
            5: begin
               mode = 4'b0111; n = 5; b = 64'($urandom_range(0, 31));
               if ($urandom_range(0, 1) == 1) cv = b[4:0];
            end
            6, 7: begin
               mode = 4'b1111; nones = $urandom_range(30, 45); n = nones + 1;
               b = ((64'd1 << nones) - 64'd1) << 1;
            end
            default: begin mode = 4'b1010; n = $urandom_range(1, 6); b = 64'($urandom_range(0, 63)); end
         endcase
         model_txn(mode, n, b, cv, cvld, d, c, e);
         run_txn(mode, n, b, cv, cvld, both);
         check_vals($sformatf("rnd%0d", t), mode, m_w[7:0], m_pre, m_err, d, c, e);
      end

      chk("exp_q_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ddr_rx.md
# ddr_rx

Receive datapath for the HDR-DDR controller. It samples SDA on every SCL edge (both rising and falling) from `scl_generation` while the CCC/DDR FSM enables it. Per the requested mode, it captures a preamble bit, deserializes a data byte, checks parity, checks the CRC token or the CRC value, or runs error recovery. It reports completion, data and errors back to the DDR FSM and the CRC block.

## Interface
- `ERR_MIN_ONES`, default 38: number of consecutive SDA-high samples required before the terminating low in error-recovery mode.
- `i_sys_clk` in 1: system clock; all logic is on the rising edge.
- `i_sys_rst` in 1: reset, synchronous, active-high.
- `i_sclgen_scl` in 1: SCL level, informational only.
- `i_sclgen_scl_pos_edge` in 1: one-cycle pulse marking an SCL rising edge.
- `i_sclgen_scl_neg_edge` in 1: one-cycle pulse marking an SCL falling edge.
- `i_ddrccc_rx_en` in 1: receiver enable.
- `i_sdahnd_rx_sda` in 1: SDA input from the SDA handler.
- `i_ddrccc_rx_mode` in 4: operation select.
- `i_crc_value` in 5: expected CRC5 from the CRC block.
- `i_crc_valid` in 1: `i_crc_value` is valid.
- `o_regfcrc_rx_data_out` out 8: last completed byte.
- `o_ddrccc_rx_mode_done` out 1: one-cycle pulse when the current mode completes.
- `o_ddrccc_pre` out 1: captured preamble bit.
- `o_ddrccc_error` out 1: sticky error flag.
- `o_crc_en` out 1: CRC engine enable.
- `o_crc_data_valid` out 1: one-cycle pulse when a byte is ready for the CRC engine.
- `o_ddrccc_error_done` out 1: one-cycle pulse when error recovery is complete.

## Operation
- **Sampling.** A sample is taken in any cycle where `i_ddrccc_rx_en` is 1 and (pos_edge | neg_edge) is 1. If both edge pulses are high in the same cycle, that counts as one sample.
- **Bit order and counter.** Bits are shifted MSB-first: the first bit received ends up in the MSB. The bit counter restarts whenever `rx_en` is 0 or `rx_mode` changes.
- **Mode 0000, PREAMBLE.** Takes 1 sample. The sample is written to `o_ddrccc_pre`, and `mode_done` pulses.
- **Mode 0011, BYTE.** Takes 8 samples.
  - `o_crc_en` is 1 throughout.
  - On the 8th sample, the byte is latched to `data_out` and kept in the word register (previous byte moves to the high half). `o_crc_data_valid` and `mode_done` both pulse.
- **Mode 0110, PARITY.** Takes 2 samples, PA1 then PA0, checked against the 16-bit word W (first byte = W[15:8]).
  - Expected PA1 = XOR of W[15,13,…,1].
  - Expected PA0 = XOR of W[14,12,…,0], inverted (XOR 1).
  - A mismatch sets the error flag. `mode_done` pulses in either case.
- **Mode 0101, TOKEN.** Takes 4 samples. Any value other than 4'hC sets the error flag. `mode_done` pulses.
- **Mode 0111, CRC.** Takes 5 samples. If `i_crc_valid` is 1 and the received value ≠ `i_crc_value`, the error flag is set. `mode_done` pulses.
- **Mode 1111, ERROR.** Counts consecutive high samples.
  - A low sample with count ≥ `ERR_MIN_ONES`: pulses `error_done` and `mode_done`, and clears `o_ddrccc_error`.
  - A low sample with count below the threshold: resets the count.
- **Other modes.** No action.
- **Error flag.** Cleared only by reset or by error-recovery completion.
- **Enable low.** Nothing is sampled; `data_out`, `pre` and `error` hold their values.

## Timing
- **Reset values.**
  - All outputs are 0, except `o_ddrccc_pre` = 1 (idle-high line).
  - Counters and the word register are cleared.
- **Output latency.** `mode_done`, `crc_data_valid`, `error_done` and the updated `data_out`/`error` are all registered. They appear in the cycle after the final sample.
- **Bit spacing.** One bit arrives every 2 clocks (edge pulses 2 cycles apart).
- **Mode changes.** The FSM may change mode the cycle after `mode_done` falls. Samples taken in the mode's first edge cycle count.
- **Reset mid-mode.** Aborts the mode with no done pulse.

## Configuration
- **`RX_CRC_CHECK_EN` defined:** mode 0111 compares against `i_crc_value` as described above.
- **`RX_CRC_CHECK_EN` undefined:** mode 0111 consumes 5 bits, pulses done and never sets the error flag.

## Structure
- **Package `ddr_rx_pkg`:** mode encodings (PREAMBLE, BYTE, TOKEN, PARITY, CRC, ERROR), `CRC_TOKEN` = 4'hC, bit-count constants per mode.
- **Sub-module `rx_bit_counter`:** sample qualify, counter with mode-change restart, and the per-mode terminal-count decode.

## Test plan
- **Preamble:** mode 0000, SDA=0 on the first edge → `mode_done` pulse, `o_ddrccc_pre`=0.
- **Bytes and good parity:** two BYTE modes, each SDA 0×8 → two `crc_data_valid` pulses with `data_out`=8'h00. Then PARITY with SDA 0,1 → `mode_done`, `error`=0.
- **Byte ordering:** BYTE, SDA sequence 1,0,0,0,0,1,0,1 → `data_out`=8'h85. Second BYTE, sequence 0,0,1,0,1,0,1,1 → `data_out`=8'h2B. PARITY with SDA 0,1 → `error`=1 (expected PA1=0, PA0=0).
- **Token:** TOKEN with SDA 1,1,0,0 → no error. Sequence 0,0,1,1 → `error`=1.
- **CRC:** `i_crc_value`=5'b10101, `crc_valid`=1, CRC mode with SDA 1,0,1,0,1 → done, no error. SDA 1,1,1,1,1 → `error`=1.
- **Error recovery:** with `error`=1, mode 1111 with 38 high samples then 0 → `error_done` and `mode_done` pulse, `error` clears. With only 10 ones then 0 → no pulse.
